// File: rtl/saber_pkg.sv
// rtl/saber_pkg.sv - shared config encodings and sequencer state type
package saber_pkg;

    localparam logic [1:0] CFG_OFF    = 2'd0;
    localparam logic [1:0] CFG_SINGLE = 2'd1;
    localparam logic [1:0] CFG_DOUBLE = 2'd2;
    localparam logic [1:0] CFG_HILTED = 2'd3;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_IGNITE  = 2'd1,
        ST_ON      = 2'd2,
        ST_RETRACT = 2'd3
    } seqState_t;

endpackage

// File: rtl/saber_step_timer.sv
// rtl/saber_step_timer.sv - free-running ramp step divider, tick every STEP_CYCLES cycles while run
module saber_step_timer #(
    parameter int STEP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = run && (count == LAST);

endmodule

// File: rtl/saber_sequencer.sv
// rtl/saber_sequencer.sv - blade ignition/retraction sequencer gating config register updates
// Optional: SABER_QUICK_RETRACT_EN makes power-drop retractions step every cycle.
module saber_sequencer
    import saber_pkg::*;
#(
    parameter int RAMP_STEPS  = 8,
    parameter int STEP_CYCLES = 4,
    parameter int LVL_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             power,
    input  logic             req_valid,
    input  logic [1:0]       req_cfg,
    output logic             req_ready,
    output logic             cfg_en,
    output logic [1:0]       cfg_set,
    output logic [LVL_W-1:0] blade_level,
    output logic             busy,
    output logic             hum_on
);

    localparam logic [LVL_W-1:0] FULL = LVL_W'(RAMP_STEPS);

    seqState_t        state, stateNext;
    logic [1:0]       pending, pendingNext, cfgNext;
    logic [LVL_W-1:0] levelNext;
    logic             accept, timerTick, stepTick, stateChange;

    assign busy        = (state == ST_IGNITE) || (state == ST_RETRACT);
    assign hum_on      = (state != ST_OFF);
    assign cfg_en      = power;
    assign req_ready   = power && ((state == ST_OFF) || (state == ST_ON));
    assign accept      = req_valid && req_ready;
    assign stateChange = (stateNext != state);

    saber_step_timer #(.STEP_CYCLES(STEP_CYCLES)) stepTimer (
        .clk  (clk),
        .rst  (rst),
        .run  (busy),
        .clear(stateChange),
        .tick (timerTick)
    );

`ifdef SABER_QUICK_RETRACT_EN
    // Remembers whether the current retraction was caused by losing power.
    logic quickRet;

    always_ff @(posedge clk) begin
        if (rst) begin
            quickRet <= 1'b0;
        end else if (stateChange) begin
            quickRet <= ((state == ST_IGNITE) || (state == ST_ON)) && !power;
        end
    end

    assign stepTick = timerTick || ((state == ST_RETRACT) && quickRet);
`else
    assign stepTick = timerTick;
`endif

    always_comb begin
        stateNext   = state;
        cfgNext     = cfg_set;
        pendingNext = pending;
        levelNext   = blade_level;
        case (state)
            ST_OFF: begin
                if (accept && (req_cfg != CFG_OFF)) begin
                    cfgNext   = req_cfg;
                    stateNext = ST_IGNITE;
                end
            end
            ST_IGNITE: begin
                // Power loss wins over a coincident step: retract from the level held now.
                if (!power) begin
                    pendingNext = CFG_OFF;
                    stateNext   = ST_RETRACT;
                end else if (stepTick) begin
                    levelNext = blade_level + 1'b1;
                    if (blade_level == FULL - 1'b1) begin
                        stateNext = ST_ON;
                    end
                end
            end
            ST_ON: begin
                if (!power) begin
                    pendingNext = CFG_OFF;
                    stateNext   = ST_RETRACT;
                end else if (accept && (req_cfg != cfg_set)) begin
                    pendingNext = req_cfg;
                    stateNext   = ST_RETRACT;
                end
            end
            ST_RETRACT: begin
                if (!power) begin
                    pendingNext = CFG_OFF;
                end
                if (stepTick) begin
                    if (blade_level > LVL_W'(1)) begin
                        levelNext = blade_level - 1'b1;
                    end else begin
                        levelNext = '0;
                        if ((pending == CFG_OFF) || !power) begin
                            cfgNext   = CFG_OFF;
                            stateNext = ST_OFF;
                        end else begin
                            cfgNext     = pending;
                            pendingNext = CFG_OFF;
                            stateNext   = ST_IGNITE;
                        end
                    end
                end
            end
            default: stateNext = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_OFF;
            cfg_set     <= CFG_OFF;
            pending     <= CFG_OFF;
            blade_level <= '0;
        end else begin
            state       <= stateNext;
            cfg_set     <= cfgNext;
            pending     <= pendingNext;
            blade_level <= levelNext;
        end
    end

endmodule

// File: tb/tb_saber_sequencer.sv
// tb/tb_saber_sequencer.sv - scoreboard bench: ramp reference model vs saber_sequencer
module tb_saber_sequencer;

    localparam int RS = 8;
    localparam int SC = 4;
`ifdef SABER_QUICK_RETRACT_EN
    localparam bit QUICK = 1'b1;
`else
    localparam bit QUICK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       power = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_cfg = 2'd0;
    logic       req_ready, cfg_en, busy, hum_on;
    logic [1:0] cfg_set;
    logic [3:0] blade_level;

    int compared = 0;
    int mismatched = 0;

    saber_sequencer #(.RAMP_STEPS(RS), .STEP_CYCLES(SC), .LVL_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .power      (power),
        .req_valid  (req_valid),
        .req_cfg    (req_cfg),
        .req_ready  (req_ready),
        .cfg_en     (cfg_en),
        .cfg_set    (cfg_set),
        .blade_level(blade_level),
        .busy       (busy),
        .hum_on     (hum_on)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cfg;
        int lvl;
        bit busy;
        bit hum;
        bit idle;
    } snap_t;

    snap_t expQ[$];

    // Reference: each ramp phase is an entry level plus elapsed cycles; the level is derived arithmetically.
    typedef enum int {M_OFF, M_IGN, M_ON, M_RET} mode_t;
    mode_t mode = M_OFF;
    int    lvl = 0, lvl0 = 0, elapsed = 0, cfg = 0, pend = 0;
    bit    quick = 0;

    task automatic enterPhase(input mode_t m);
        mode    = m;
        lvl0    = lvl;
        elapsed = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mode = M_OFF; lvl = 0; lvl0 = 0; elapsed = 0; cfg = 0; pend = 0; quick = 0;
            end else begin
                bit acc;
                int per, steps;
                acc = req_valid && power && (mode == M_OFF || mode == M_ON);
                case (mode)
                    M_OFF: if (acc && req_cfg != 0) begin
                        cfg = int'(req_cfg);
                        enterPhase(M_IGN);
                    end
                    M_IGN: if (!power) begin
                        pend = 0; quick = 1;
                        enterPhase(M_RET);
                    end else begin
                        elapsed++;
                        lvl = lvl0 + elapsed / SC;
                        if (lvl >= RS) begin
                            lvl = RS;
                            mode = M_ON;
                        end
                    end
                    M_ON: if (!power) begin
                        pend = 0; quick = 1;
                        enterPhase(M_RET);
                    end else if (acc && int'(req_cfg) != cfg) begin
                        pend = int'(req_cfg); quick = 0;
                        enterPhase(M_RET);
                    end
                    M_RET: begin
                        if (!power) pend = 0;
                        elapsed++;
                        per   = (QUICK && quick) ? 1 : SC;
                        steps = elapsed / per;
                        lvl   = (lvl0 > steps) ? lvl0 - steps : 0;
                        if (steps >= ((lvl0 > 1) ? lvl0 : 1)) begin
                            lvl = 0;
                            if (pend == 0) begin
                                cfg = 0;
                                enterPhase(M_OFF);
                            end else begin
                                cfg = pend; pend = 0;
                                enterPhase(M_IGN);
                            end
                        end
                    end
                    default: mode = M_OFF;
                endcase
            end
            expQ.push_back('{cfg, lvl, (mode == M_IGN || mode == M_RET), (mode != M_OFF),
                             (mode == M_OFF || mode == M_ON)});
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                snap_t s;
                s = expQ.pop_front();
                check("cfg_set", 8'(cfg_set), 8'(s.cfg));
                check("blade_level", 8'(blade_level), 8'(s.lvl));
                check("busy", 8'(busy), 8'(s.busy));
                check("hum_on", 8'(hum_on), 8'(s.hum));
                check("req_ready", 8'(req_ready), 8'(power && s.idle));
                check("cfg_en", 8'(cfg_en), 8'(power));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic request(input logic [1:0] c);
        req_valid = 1'b1;
        req_cfg   = c;
        cyc(1);
        req_valid = 1'b0;
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(2);
        // Ignition to double, then reconfigure to hilted
        power = 1'b1;
        request(2'd2);
        cyc(40);
        request(2'd3);
        cyc(2);
        // Held request through retract/ignite is only taken once ON (and equals current cfg)
        req_valid = 1'b1;
        req_cfg   = 2'd3;
        cyc(80);
        req_valid = 1'b0;
        // Retract by request, then power drop mid-ignite at level 5
        request(2'd0);
        cyc(40);
        request(2'd1);
        cyc(21);
        power     = 1'b0;
        req_valid = 1'b1;
        req_cfg   = 2'd2;
        cyc(30);
        req_valid = 1'b0;
        // Power drop before the first step: retract from level 0
        power = 1'b1;
        request(2'd1);
        cyc(2);
        power = 1'b0;
        cyc(8);
        // Power restored during retraction must not re-ignite
        power = 1'b1;
        request(2'd2);
        cyc(40);
        power = 1'b0;
        cyc(3);
        power = 1'b1;
        cyc(40);
        // Reset mid-retract at level 3
        request(2'd1);
        cyc(40);
        request(2'd0);
        cyc(20);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(2);
        // OFF no-op
        request(2'd0);
        cyc(3);
        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) power = ~power;
            req_valid = ($urandom_range(0, 7) == 0);
            req_cfg   = 2'($urandom_range(0, 3));
            rst       = ($urandom_range(0, 599) == 0);
            cyc(1);
        end
        rst = 1'b0;
        req_valid = 1'b0;
        cyc(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
